scroll_controller: RTL and testbench

- Sequences the 7-position digit rotator (left-scroll of a 7-symbol message across the 4-digit display) by generating its 3-bit rotation state.
- Supports timed auto-scroll, single-step, and a direction register.
- Also time-multiplexes the rotator's four 5-bit digit codes onto the shared 4-anode seven-segment display: one digit code out plus active-low anodes.
- Sits between board buttons/switches and the rotator / segment decoder.

---
 rtl/scroll_controller.sv | 147 ++++++++++++++
 tb/tb_scroll_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/scroll_controller.sv
// scroll_controller: sequences the digit rotator's rotation state and scans the
// four rotator digit codes onto a shared 4-anode seven-segment display.
//
// Optional feature: define SCROLL_BOUNCE_EN for ping-pong scrolling. The scroll
// reverses at each end instead of wrapping around.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   run         level, 1 = timed auto-scroll
//   step        one-cycle pulse, single advance while run = 0
//   dir_toggle  one-cycle pulse, flips scroll direction
//   seg0..seg3  digit codes from the rotator (seg0 = rightmost)
//   state       rotation state, 0..NUM_POS-1
//   dir         1 = forward (increment), 0 = reverse
//   adv         one-cycle pulse, the cycle after state changed
//   digit       code of the currently lit digit
//   an          active-low one-hot anode enables
module scroll_controller #(
  parameter int unsigned NUM_POS  = 7,
  parameter int unsigned STEP_DIV = 50000000,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       step,
  input  logic       dir_toggle,
  input  logic [4:0] seg0,
  input  logic [4:0] seg1,
  input  logic [4:0] seg2,
  input  logic [4:0] seg3,
  output logic [2:0] state,
  output logic       dir,
  output logic       adv,
  output logic [4:0] digit,
  output logic [3:0] an
);

  localparam int unsigned STEP_W = $clog2(STEP_DIV);
  localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
  localparam logic [2:0]        LAST      = 3'(NUM_POS - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic              step_term;
  logic              adv_req;
  logic [2:0]        state_d;
  logic              dir_d;

  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic              scan_term;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        an_d;

  // Auto-scroll prescaler: held at zero while stopped so the first advance
  // lands exactly STEP_DIV cycles after run rises.
  always_comb begin
    step_term  = run && (step_cnt_q == STEP_LAST);
    step_cnt_d = '0;
    if (run && !step_term) begin
      step_cnt_d = step_cnt_q + STEP_W'(1);
    end
    // step is ignored while auto-scrolling
    adv_req = run ? step_term : step;
  end

  // Next rotation state. A coincident toggle only affects later advances,
  // except at a bounce endpoint where the bounce owns the direction.
  always_comb begin
    state_d = state;
    dir_d   = dir ^ dir_toggle;
    if (adv_req) begin
      if (dir) begin
        if (state == LAST) begin
`ifdef SCROLL_BOUNCE_EN
          state_d = LAST - 3'd1;
          dir_d   = 1'b0;
`else
          state_d = 3'd0;
`endif
        end else begin
          state_d = state + 3'd1;
        end
      end else begin
        if (state == 3'd0) begin
`ifdef SCROLL_BOUNCE_EN
          state_d = 3'd1;
          dir_d   = 1'b1;
`else
          state_d = LAST;
`endif
        end else begin
          state_d = state - 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt_q <= '0;
      state      <= 3'd0;
      dir        <= 1'b1;
      adv        <= 1'b0;
    end else begin
      step_cnt_q <= step_cnt_d;
      state      <= state_d;
      dir        <= dir_d;
      adv        <= adv_req;
    end
  end

  // Display scan, free-running and independent of the scroll logic.
  always_comb begin
    scan_term  = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d = scan_term ? '0 : scan_cnt_q + SCAN_W'(1);
    idx_d      = idx_q + 2'(scan_term);
    an_d       = ~(4'b0001 << idx_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q <= '0;
      idx_q      <= 2'd0;
      an         <= 4'b1110;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      an         <= an_d;
    end
  end

  // Selected from the registered index so digit always matches an.
  always_comb begin
    digit = seg0;
    unique case (idx_q)
      2'd0: digit = seg0;
      2'd1: digit = seg1;
      2'd2: digit = seg2;
      2'd3: digit = seg3;
      default: digit = seg0;
    endcase
  end

endmodule

// File: tb/tb_scroll_controller.sv
// Self-checking bench for scroll_controller with small dividers. Directed table
// rows, hand-written scan/reset/wrap sequences, then randomized stimulus; a
// behavioural model is compared against the DUT on every falling edge.
module tb_scroll_controller;

  localparam int NUM_POS  = 7;
  localparam int STEP_DIV = 4;
  localparam int SCAN_DIV = 2;

  logic       clk = 1'b0;
  logic       rst, run, step, dir_toggle;
  logic [4:0] seg0, seg1, seg2, seg3;
  logic [2:0] state;
  logic       dir, adv;
  logic [4:0] digit;
  logic [3:0] an;

  int nchecks = 0;
  int nerrors = 0;
  bit chk_en  = 1'b0;

  scroll_controller #(
    .NUM_POS (NUM_POS),
    .STEP_DIV(STEP_DIV),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .step      (step),
    .dir_toggle(dir_toggle),
    .seg0      (seg0),
    .seg1      (seg1),
    .seg2      (seg2),
    .seg3      (seg3),
    .state     (state),
    .dir       (dir),
    .adv       (adv),
    .digit     (digit),
    .an        (an)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: counts run cycles and scan cycles with plain arithmetic.
  int m_state, m_dir, m_adv, m_runcnt, m_scan;
  int ns, nd;
  bit m_req;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0; m_dir = 1; m_adv = 0; m_runcnt = 0; m_scan = 0;
    end else begin
      m_req    = run ? ((m_runcnt % STEP_DIV) == STEP_DIV - 1) : step;
      m_runcnt = run ? m_runcnt + 1 : 0;
      nd = dir_toggle ? 1 - m_dir : m_dir;
      ns = m_state;
      if (m_req) begin
        if (m_dir == 1) begin
          ns = (m_state + 1) % NUM_POS;
`ifdef SCROLL_BOUNCE_EN
          if (m_state == NUM_POS - 1) begin ns = NUM_POS - 2; nd = 0; end
`endif
        end else begin
          ns = (m_state + NUM_POS - 1) % NUM_POS;
`ifdef SCROLL_BOUNCE_EN
          if (m_state == 0) begin ns = 1; nd = 1; end
`endif
        end
      end
      m_state = ns; m_dir = nd; m_adv = int'(m_req); m_scan++;
    end
  end

  logic [4:0] segs [4];
  int         eidx;
  logic [3:0] ean;

  always @(negedge clk) begin
    if (chk_en) begin
      segs[0] = seg0; segs[1] = seg1; segs[2] = seg2; segs[3] = seg3;
      eidx = (m_scan / SCAN_DIV) % 4;
      ean  = 4'b0001 << eidx;
      ean  = ~ean;
      check("model_state", int'(state), m_state);
      check("model_dir",   int'(dir),   m_dir);
      check("model_adv",   int'(adv),   m_adv);
      check("model_an",    int'(an),    int'(ean));
      check("model_digit", int'(digit), int'(segs[eidx]));
    end
  end

  typedef struct {
    logic run;
    logic stp;
    logic tog;
    int   n;
    int   exp_state;
    int   exp_dir;
  } row_t;

  row_t       tbl [11];
  logic [3:0] scan_an  [6];
  logic [4:0] scan_dig [6];
  int         maxs;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 20, 0, 1};
`ifdef SCROLL_BOUNCE_EN
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 28, 5, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1,  5, 1};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 3,  6, 1};
`else
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 28, 0, 1};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1,  0, 0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 3,  6, 0};
`endif
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 3,  5, 0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 3,  4, 0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 3,  3, 0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1,  3, 1};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 3,  3, 1};  // step ignored while running
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1,  4, 0};  // toggle on an auto advance
    tbl[10] = '{1'b1, 1'b0, 1'b0, 4,  3, 0};
    scan_an  = '{4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111};
    scan_dig = '{5'h01, 5'h02, 5'h02, 5'h03, 5'h03, 5'h04};

    rst = 1'b0; run = 1'b0; step = 1'b0; dir_toggle = 1'b0;
    seg0 = 5'h01; seg1 = 5'h02; seg2 = 5'h03; seg3 = 5'h04;

    // Asynchronous reset between edges
    #7 rst = 1'b1;
    #1;
    check("rst_state", int'(state), 0);
    check("rst_dir",   int'(dir),   1);
    check("rst_adv",   int'(adv),   0);
    check("rst_an",    int'(an),    int'(4'b1110));
    check("rst_digit", int'(digit), 1);
    chk_en = 1'b1;
    tick();
    rst = 1'b0;

    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].n; c++) begin
        run        = tbl[i].run;
        step       = tbl[i].stp && (c == 0);
        dir_toggle = tbl[i].tog && (c == 0);
        tick();
      end
      step = 1'b0; dir_toggle = 1'b0;
      check($sformatf("row%0d_state", i), int'(state), tbl[i].exp_state);
      check($sformatf("row%0d_dir", i),   int'(dir),   tbl[i].exp_dir);
    end

    // Scan sequence from a fresh reset, then reset in the middle of it
    run = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("scan%0d_an", k),    int'(an),    int'(scan_an[k]));
      check($sformatf("scan%0d_digit", k), int'(digit), int'(scan_dig[k]));
    end
    rst = 1'b1;
    #1;
    check("midscan_rst_an",    int'(an),    int'(4'b1110));
    check("midscan_rst_digit", int'(digit), 1);
    tick();
    rst = 1'b0;

    // 56 cycles of auto-scroll: wrap or bounce
    run  = 1'b1;
    maxs = 0;
    for (int c = 0; c < 56; c++) begin
      tick();
      if (int'(state) > maxs) maxs = int'(state);
    end
    check("long_max_state", maxs, 6);
`ifdef SCROLL_BOUNCE_EN
    check("long_end_state", int'(state), 2);
`else
    check("long_end_state", int'(state), 0);
`endif
    check("long_end_dir", int'(dir), 1);

    // Randomized stimulus against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 15) == 0) run = ~run;
      step       = ($urandom_range(0, 3) == 0);
      dir_toggle = ($urandom_range(0, 7) == 0);
      seg0 = 5'($urandom); seg1 = 5'($urandom);
      seg2 = 5'($urandom); seg3 = 5'($urandom);
      rst  = ($urandom_range(0, 199) == 0);
      tick();
      rst = 1'b0;
    end
    step = 1'b0; dir_toggle = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
